// File: rtl/md_ctrl_unit.sv
// Multiply/divide sequencer for the execute stage. It owns HI/LO, runs long ops
// for a fixed latency and requests a front-end stall while a result is pending.
module md_ctrl_unit #(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              stall,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] md_out
);

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_MSUB     = 6'b011100;
  localparam logic [5:0] F_MULT      = 6'b011000;
  localparam logic [5:0] F_MULTU     = 6'b011001;
  localparam logic [5:0] F_DIV       = 6'b011010;
  localparam logic [5:0] F_DIVU      = 6'b011011;
  localparam logic [5:0] F_MTHI      = 6'b010001;
  localparam logic [5:0] F_MTLO      = 6'b010011;
  localparam logic [5:0] F_MFHI      = 6'b010000;
  localparam logic [5:0] F_MFLO      = 6'b010010;
  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] p_hi, p_lo, p_hi_nx, p_lo_nx, hi_nx, lo_nx;

  logic is_sp, dec_mult, dec_multu, dec_div, dec_divu, dec_msub;
  logic dec_mthi, dec_mtlo, dec_mfhi, dec_mflo, dec_long, dec_any, start;

  assign is_sp     = valid && (op == OP_SPECIAL);
  assign dec_mult  = is_sp && (func == F_MULT);
  assign dec_multu = is_sp && (func == F_MULTU);
  assign dec_div   = is_sp && (func == F_DIV);
  assign dec_divu  = is_sp && (func == F_DIVU);
  assign dec_mthi  = is_sp && (func == F_MTHI);
  assign dec_mtlo  = is_sp && (func == F_MTLO);
  assign dec_mfhi  = is_sp && (func == F_MFHI);
  assign dec_mflo  = is_sp && (func == F_MFLO);
  assign dec_msub  = valid && (op == OP_MSUB);
  assign dec_long  = dec_mult | dec_multu | dec_div | dec_divu | dec_msub;
  assign dec_any   = dec_long | dec_mthi | dec_mtlo | dec_mfhi | dec_mflo;
  assign start     = (state == IDLE) && dec_long;

  assign busy   = (state == BUSY);
  assign stall  = busy && dec_any;
  assign md_out = dec_mfhi ? hi : (dec_mflo ? lo : '0);

  // Products: only the low 2*DATA_W bits are kept, so an unsigned multiply of
  // sign- or zero-extended operands gives the signed or unsigned result.
  logic [2*DATA_W-1:0] rs_sx, rt_sx, rs_zx, rt_zx, prod_s, prod_u, acc_sub;
  assign rs_sx   = {{DATA_W{rs_val[DATA_W-1]}}, rs_val};
  assign rt_sx   = {{DATA_W{rt_val[DATA_W-1]}}, rt_val};
  assign rs_zx   = {{DATA_W{1'b0}}, rs_val};
  assign rt_zx   = {{DATA_W{1'b0}}, rt_val};
  assign prod_s  = rs_sx * rt_sx;
  assign prod_u  = rs_zx * rt_zx;
  assign acc_sub = {hi, lo} - prod_s;

  // Dividing by 1 instead of -1 in the overflow case yields exactly the
  // required quotient (most-negative) and remainder (0); zero divisors are
  // also replaced so the divider never sees 0.
  logic                     div_zero, div_ovf;
  logic signed [DATA_W-1:0] sdvd, sdvs, squo, srem;
  logic        [DATA_W-1:0] udvs, uquo, urem;
  assign div_zero = (rt_val == '0);
  assign div_ovf  = (rs_val == {1'b1, {(DATA_W-1){1'b0}}}) && (rt_val == '1);
  assign sdvd     = rs_val;
  assign sdvs     = (div_zero || div_ovf) ? DATA_W'(1) : rt_val;
  assign squo     = sdvd / sdvs;
  assign srem     = sdvd % sdvs;
  assign udvs     = div_zero ? DATA_W'(1) : rt_val;
  assign uquo     = rs_val / udvs;
  assign urem     = rs_val % udvs;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    p_hi_nx  = p_hi;
    p_lo_nx  = p_lo;
    hi_nx    = hi;
    lo_nx    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = BUSY;
          cnt_nx   = (dec_div || dec_divu) ? DIV_LAT : MULT_LAT;
          {p_hi_nx, p_lo_nx} = {hi, lo};
          if (dec_mult)                    {p_hi_nx, p_lo_nx} = prod_s;
          else if (dec_multu)              {p_hi_nx, p_lo_nx} = prod_u;
          else if (dec_msub)               {p_hi_nx, p_lo_nx} = acc_sub;
          else if (dec_div && !div_zero)   {p_hi_nx, p_lo_nx} = {srem, squo};
          else if (dec_divu && !div_zero)  {p_hi_nx, p_lo_nx} = {urem, uquo};
        end else if (dec_mthi) begin
          hi_nx = rs_val;
        end else if (dec_mtlo) begin
          lo_nx = rs_val;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          hi_nx    = p_hi;
          lo_nx    = p_lo;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      p_hi  <= p_hi_nx;
      p_lo  <= p_lo_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end

endmodule

// File: tb/tb_md_ctrl_unit.sv
// Bench for md_ctrl_unit: directed plan cases, random long ops against a
// reference model, and a MULT_CYCLES=1 instance for the short-latency corner.
module tb_md_ctrl_unit;
  localparam int W = 32;
  localparam logic [5:0] OP_MSUB = 6'b011100;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_ADD   = 6'b100000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         valid = 1'b0;
  logic [5:0]   op = '0, func = '0;
  logic [W-1:0] rs_val = '0, rt_val = '0;
  logic         busy, stall;
  logic [W-1:0] hi, lo, md_out;

  logic         valid1 = 1'b0;
  logic [5:0]   op1 = '0, func1 = '0;
  logic [W-1:0] rs1 = '0, rt1 = '0;
  logic         busy1, stall1;
  logic [W-1:0] hi1, lo1, md_out1;

  md_ctrl_unit #(.DATA_W(W), .MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .op(op), .func(func),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .md_out(md_out)
  );

  md_ctrl_unit #(.DATA_W(W), .MULT_CYCLES(1), .DIV_CYCLES(10), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid(valid1), .op(op1), .func(func1),
    .rs_val(rs1), .rt_val(rt1), .busy(busy1), .stall(stall1),
    .hi(hi1), .lo(lo1), .md_out(md_out1)
  );

  // scoreboard
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_hi = '0, m_lo = '0;
  int             n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic step(input logic v, input logic [5:0] o, input logic [5:0] f,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    valid = v; op = o; func = f; rs_val = a; rt_val = b;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid = 1'b0; op = '0; func = '0;
  endtask

  task automatic push_long(input logic [5:0] o, input logic [5:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb, sq, sr;
    logic        [2*W-1:0] ua, ub, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r  = {m_hi, m_lo};
    if (o == OP_MSUB) r = {m_hi, m_lo} - sa * sb;
    else if (f == F_MULT) r = sa * sb;
    else if (f == F_MULTU) r = ua * ub;
    else if (f == F_DIV && b != '0) begin
      sq = sa / sb;
      sr = sa % sb;
      r  = {sr[W-1:0], sq[W-1:0]};
    end else if (f == F_DIVU && b != '0) begin
      r = {ua[W-1:0] % ub[W-1:0], ua[W-1:0] / ub[W-1:0]};
    end
    exp_q.push_back(r);
    {m_hi, m_lo} = r;
  endtask

  task automatic start_long(input logic [5:0] o, input logic [5:0] f,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    push_long(o, f, a, b);
    step(1'b1, o, f, a, b);
    idle_inputs();
  endtask

  task automatic compare_commit(input string tag);
    logic [2*W-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  task automatic wait_commit(input string tag, input int exp_cyc);
    int cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cyc, exp_cyc);
    compare_commit(tag);
  endtask

  task automatic move_to(input logic [5:0] f, input logic [W-1:0] a);
    step(1'b1, 6'b000000, f, a, '0);
    idle_inputs();
    if (f == F_MTHI) m_hi = a; else m_lo = a;
    check("mt_hilo", {hi, lo}, {m_hi, m_lo});
    check("mt_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_busy", {busy, stall}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a mult discards the pending result
    step(1'b1, 6'b000000, F_MULT, 32'd5, 32'd7);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_hilo", {hi, lo}, 0);
    repeat (8) @(negedge clk);
    check("midrst_late_hilo", {hi, lo}, 0);

    start_long(6'b000000, F_MULT, 32'hFFFF_FFFE, 32'h3);
    wait_commit("mult", 5);
    check("mult_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    start_long(6'b000000, F_MULTU, 32'hFFFF_FFFE, 32'h3);
    wait_commit("multu", 5);
    check("multu_lit", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});

    start_long(6'b000000, F_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_commit("div", 10);
    check("div_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    move_to(F_MTHI, 32'h11);
    move_to(F_MTLO, 32'h22);
    start_long(6'b000000, F_DIVU, 32'h7, 32'h0);
    wait_commit("divu0", 10);
    check("divu0_lit", {hi, lo}, {32'h11, 32'h22});

    start_long(6'b000000, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit("div_ovf", 10);
    check("div_ovf_lit", {hi, lo}, {32'h0, 32'h8000_0000});

    // mflo held behind a mult, then reads the committed LO
    start_long(6'b000000, F_MULT, 32'h1234_5678, 32'hFEDC_BA98);
    valid = 1'b1; op = '0; func = F_MFLO;
    #1;
    cyc = 0;
    while (stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    check("mflo_stall_cycles", cyc, 5);
    compare_commit("mflo_mult");
    check("mflo_md_out", md_out, m_lo);
    func = F_MFHI;
    #1;
    check("mfhi_md_out", md_out, m_hi);
    @(negedge clk);
    idle_inputs();

    // non-md instruction flows while busy
    start_long(6'b000000, F_MULTU, 32'hDEAD_BEEF, 32'h0000_1001);
    valid = 1'b1; op = '0; func = F_ADD;
    #1;
    check("add_stall", {busy, stall}, 2'b10);
    check("add_md_out", md_out, 0);
    idle_inputs();
    wait_commit("mult_add", 5);

    move_to(F_MTHI, 32'h0);
    move_to(F_MTLO, 32'd10);
    start_long(OP_MSUB, 6'b000000, 32'd2, 32'd3);
    wait_commit("msub1", 5);
    check("msub1_lit", {hi, lo}, {32'h0, 32'h4});
    start_long(OP_MSUB, 6'b000000, 32'd2, 32'd3);
    wait_commit("msub2", 5);
    check("msub2_lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});

    // invalid slot carrying a mult encoding does nothing
    step(1'b0, 6'b000000, F_MULT, 32'd9, 32'd9);
    check("novalid_busy", busy, 0);
    check("novalid_hilo", {hi, lo}, {m_hi, m_lo});

    for (int i = 0; i < 10; i++) begin
      logic [5:0] o, f;
      int k;
      k = $urandom_range(0, 4);
      o = (k == 4) ? OP_MSUB : 6'b000000;
      f = (k == 0) ? F_MULT : (k == 1) ? F_MULTU : (k == 2) ? F_DIV : (k == 3) ? F_DIVU : 6'b000000;
      start_long(o, f, $urandom(), ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom());
      wait_commit("rand", (k == 2 || k == 3) ? 10 : 5);
    end

    // single-cycle mult instance: mfhi stalls exactly one cycle
    valid1 = 1'b1; op1 = '0; func1 = F_MULT; rs1 = 32'hFFFF_FFFE; rt1 = 32'h3;
    @(negedge clk);
    func1 = F_MFHI;
    #1;
    check("m1_stall", {busy1, stall1}, 2'b11);
    @(negedge clk);
    #1;
    check("m1_after", {busy1, stall1}, 0);
    check("m1_md_out", md_out1, 32'hFFFF_FFFF);
    check("m1_lo", lo1, 32'hFFFF_FFFA);
    valid1 = 1'b0; func1 = F_MULT; rs1 = 32'd4;
    @(negedge clk);
    check("m1_novalid", busy1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
